// File: rtl/traceback_unit.sv
// Viterbi survivor-path traceback: collects ACS decision vectors for one frame,
// traces back from the final best state, then replays the decoded bits in order.
module traceback_unit #(
  parameter int NUM_STATE = 4,
  parameter int TB_DEPTH  = 16,
  localparam int STATE_W  = $clog2(NUM_STATE)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_dec_valid,
  input  logic [NUM_STATE-1:0] i_dec,
  input  logic               i_frame_end,
  input  logic [STATE_W-1:0] i_best_state,
  output logic               o_ready,
  output logic               o_valid,
  output logic               o_data,
  output logic               o_start,
  output logic               o_overflow
);

  localparam int PTR_W = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
  localparam int LEN_W = $clog2(TB_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TB_DEPTH - 1);

  // state   | meaning
  // COLLECT | accepting decision vectors into survivor memory
  // TRACE   | one traceback step per cycle, idx = len-1 .. 0
  // OUTPUT  | replaying bit_buf[0..len-1], o_valid high every cycle
  typedef enum logic [1:0] {COLLECT, TRACE, OUTPUT} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]   idx, idx_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic [LEN_W-1:0]   out_idx, out_idx_nxt;
  logic [STATE_W-1:0] s, s_nxt;
  logic               valid_nxt, data_nxt, start_nxt, overflow_nxt;
  logic               mem_we, buf_we;
  logic               pred_bit;

  logic [NUM_STATE-1:0] mem [TB_DEPTH];
  logic [TB_DEPTH-1:0]  bit_buf;

  assign pred_bit = mem[idx][s];
  assign o_ready  = (state == COLLECT);

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    idx_nxt      = idx;
    len_nxt      = len;
    out_idx_nxt  = out_idx;
    s_nxt        = s;
    valid_nxt    = 1'b0;
    data_nxt     = 1'b0;
    start_nxt    = 1'b0;
    overflow_nxt = o_overflow | (i_dec_valid && (state != COLLECT));
    mem_we       = 1'b0;
    buf_we       = 1'b0;
    case (state)
      COLLECT: begin
        if (i_dec_valid) begin
          mem_we = 1'b1;
          if (i_frame_end || (wr_ptr == LAST_PTR)) begin
            s_nxt      = i_best_state;
            len_nxt    = LEN_W'(wr_ptr) + LEN_W'(1);
            idx_nxt    = wr_ptr;
            wr_ptr_nxt = '0;
            state_nxt  = TRACE;
          end else begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
          end
        end
      end
      TRACE: begin
        buf_we = 1'b1;
        s_nxt  = {pred_bit, s[STATE_W-1:1]};
        if (idx == '0) begin
          // bit 0 is still being written this edge, so forward it straight out
          valid_nxt   = 1'b1;
          data_nxt    = s[0];
          start_nxt   = 1'b1;
          out_idx_nxt = LEN_W'(1);
          state_nxt   = OUTPUT;
        end else begin
          idx_nxt = idx - PTR_W'(1);
        end
      end
      OUTPUT: begin
        if (out_idx == len) begin
          out_idx_nxt = '0;
          state_nxt   = COLLECT;
        end else begin
          valid_nxt   = 1'b1;
          data_nxt    = bit_buf[out_idx[PTR_W-1:0]];
          out_idx_nxt = out_idx + LEN_W'(1);
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= COLLECT;
      wr_ptr     <= '0;
      idx        <= '0;
      len        <= '0;
      out_idx    <= '0;
      s          <= '0;
      o_valid    <= 1'b0;
      o_data     <= 1'b0;
      o_start    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      idx        <= idx_nxt;
      len        <= len_nxt;
      out_idx    <= out_idx_nxt;
      s          <= s_nxt;
      o_valid    <= valid_nxt;
      o_data     <= data_nxt;
      o_start    <= start_nxt;
      o_overflow <= overflow_nxt;
    end
  end

  // Storage arrays carry no reset; they are always written before being read.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_ptr] <= i_dec;
    if (buf_we) bit_buf[idx] <= s[0];
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: per-cycle comparison against a frame-level
// model plus literal checks on captured output sequences.
module tb_traceback_unit;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_dec_valid = 1'b0;
  logic [3:0] i_dec = '0;
  logic       i_frame_end = 1'b0;
  logic [1:0] i_best_state = '0;
  logic       o_ready, o_valid, o_data, o_start, o_overflow;

  traceback_unit #(.NUM_STATE(4), .TB_DEPTH(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_dec_valid(i_dec_valid), .i_dec(i_dec),
    .i_frame_end(i_frame_end), .i_best_state(i_best_state), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .o_start(o_start), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  bit exp_v [1024];
  bit exp_d [1024];
  bit exp_s [1024];
  bit exp_busy [1024];
  int ovf_cycle = 1 << 30;
  int q [$];
  int last_t = 0;
  int last_len = 0;
  int model_packed = 0;

  int got_n = 0;
  int got_packed = 0;
  int got_starts = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // Frame model: trace back from best through the stored decisions, then place
  // the bits len+1 cycles after the accept cycle, busy for 2*len cycles.
  function automatic void schedule(input int t_acc, input int best);
    int bits [16];
    int n = q.size();
    int st = best;
    for (int t = n - 1; t >= 0; t--) begin
      bits[t] = st & 1;
      st = (st >> 1) | (((q[t] >> st) & 1) << 1);
    end
    model_packed = 0;
    for (int i = 0; i < n; i++) begin
      model_packed = (model_packed << 1) | bits[i];
      exp_v[t_acc + n + 1 + i] = 1'b1;
      exp_d[t_acc + n + 1 + i] = bits[i][0];
      exp_s[t_acc + n + 1 + i] = (i == 0);
    end
    for (int k = t_acc + 1; k <= t_acc + 2 * n; k++) exp_busy[k] = 1'b1;
    last_t = t_acc;
    last_len = n;
  endfunction

  always @(negedge i_clk) begin
    if (checking) begin
      chk("o_valid", o_valid, exp_v[cyc]);
      chk("o_data", o_data, exp_d[cyc]);
      chk("o_start", o_start, exp_s[cyc]);
      chk("o_ready", o_ready, !exp_busy[cyc]);
      chk("o_overflow", o_overflow, cyc >= ovf_cycle);
      if (o_valid === 1'b1) begin
        got_n++;
        got_packed = (got_packed << 1) | int'(o_data);
        if (o_start === 1'b1) got_starts++;
      end
    end
  end

  task automatic step(input logic [3:0] dec, input logic fe, input logic [1:0] best);
    i_dec_valid = 1'b1;
    i_dec = dec;
    i_frame_end = fe;
    i_best_state = best;
    if (!exp_busy[cyc]) begin
      q.push_back(int'(dec));
      if (fe || q.size() == 16) begin
        schedule(cyc, int'(best));
        q.delete();
      end
    end else if (ovf_cycle > cyc + 1) begin
      ovf_cycle = cyc + 1;
    end
    @(posedge i_clk); #1;
    i_dec_valid = 1'b0;
    i_frame_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic wait_done();
    while (cyc <= last_t + 2 * last_len) idle(1);
  endtask

  task automatic clr_got();
    got_n = 0;
    got_packed = 0;
    got_starts = 0;
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_ready", o_ready, 1);
    chk("reset_valid", o_valid, 0);
    chk("reset_start", o_start, 0);
    chk("reset_data", o_data, 0);
    chk("reset_overflow", o_overflow, 0);
    i_rst_n = 1'b1;
    checking = 1'b1;

    // all-zero decisions, best 0, 8 steps
    clr_got();
    for (int k = 0; k < 8; k++) step(4'b0000, k == 7, 2'd0);
    wait_done();
    chk("zero_frame_count", got_n, 8);
    chk("zero_frame_bits", got_packed, 0);
    chk("zero_frame_starts", got_starts, 1);

    // hand-traced 4-step frame
    clr_got();
    step(4'b1101, 1'b0, 2'd3);
    step(4'b1011, 1'b0, 2'd3);
    step(4'b0010, 1'b0, 2'd3);
    step(4'b0111, 1'b1, 2'd3);
    chk("model_pin_1011", model_packed, 4'b1011);
    wait_done();
    chk("frame4_count", got_n, 4);
    chk("frame4_bits", got_packed, 4'b1011);

    // 16 steps without frame end: forced close at TB_DEPTH
    clr_got();
    for (int k = 0; k < 16; k++) step(4'((k * 5 + 3) % 16), 1'b0, 2'd2);
    chk("ready_after_forced", o_ready, 0);
    wait_done();
    chk("forced_count", got_n, 16);
    chk("forced_starts", got_starts, 1);

    // decisions arriving during TRACE are dropped and flagged
    clr_got();
    step(4'b0110, 1'b0, 2'd1);
    step(4'b1001, 1'b0, 2'd1);
    step(4'b0101, 1'b0, 2'd1);
    step(4'b1100, 1'b0, 2'd1);
    step(4'b0011, 1'b1, 2'd1);
    step(4'b1001, 1'b0, 2'd2);
    step(4'b0110, 1'b1, 2'd0);
    step(4'b1010, 1'b0, 2'd3);
    wait_done();
    chk("overflow_sticky", o_overflow, 1);
    chk("overflow_frame_count", got_n, 5);

    // reset during the third output bit
    clr_got();
    for (int k = 0; k < 6; k++) step(4'((k * 7 + 1) % 16), k == 5, 2'd2);
    while (cyc < last_t + last_len + 3) idle(1);
    chk("pre_reset_valid", o_valid, 1);
    i_rst_n = 1'b0;
    for (int k = cyc; k < 1024; k++) begin
      exp_v[k] = 1'b0; exp_d[k] = 1'b0; exp_s[k] = 1'b0; exp_busy[k] = 1'b0;
    end
    ovf_cycle = 1 << 30;
    q.delete();
    #1;
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_ready", o_ready, 1);
    chk("rst_mid_overflow", o_overflow, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    clr_got();
    step(4'b0000, 1'b1, 2'd1);
    wait_done();
    chk("len1_count", got_n, 1);
    chk("len1_bit", got_packed, 1);
    chk("len1_starts", got_starts, 1);

    // back-to-back frames
    clr_got();
    step(4'b1010, 1'b0, 2'd1);
    step(4'b0110, 1'b0, 2'd1);
    step(4'b1111, 1'b1, 2'd1);
    wait_done();
    step(4'b0101, 1'b0, 2'd2);
    step(4'b0011, 1'b1, 2'd2);
    wait_done();
    chk("b2b_count", got_n, 5);
    chk("b2b_bits", got_packed, 5'b10110);
    chk("b2b_overflow", o_overflow, 0);

    idle(2);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
